// File: rtl/time_setter.sv
// time_setter: debounces the set buttons, runs the RUN/SET mode FSM, and drives adjust pulses, run enable and blink mask.
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   btn_mode          raw mode button, asynchronous, active-high
//   btn_up, btn_down  raw increase/decrease buttons, asynchronous, active-high
//   en                clock run enable, high only in RUN
//   signal_increase   one-cycle increase pulse {hour, minute, second}
//   signal_decrease   one-cycle decrease pulse {hour, minute, second}
//   set_mode          00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
//   blink_mask        1 blanks that field this cycle {hour, minute, second}
module time_setter #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_DELAY    = 12_500_000,
    parameter int REPEAT_RATE     = 2_500_000,
    parameter int BLINK_HALF      = 6_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       en,
    output logic [2:0] signal_increase,
    output logic [2:0] signal_decrease,
    output logic [1:0] set_mode,
    output logic [2:0] blink_mask
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_MAX = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_MAX  = RW'(REPEAT_RATE - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    state_t        state, state_n;
    logic [2:0]    raw, sync1, sync2, deb, rise;
    logic [DW-1:0] dcnt [3];
    logic          arm_up, arm_dn, arm_up_n, arm_dn_n;
    logic          first, first_n, phase, phase_n, en_n;
    logic [RW-1:0] rcnt, rcnt_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [2:0]    field, inc_n, dec_n, blink_n;
    logic          both, held, fire;

    function automatic logic [2:0] field_of(input state_t s);
        return s == SET_HOUR ? 3'b100 : s == SET_MIN ? 3'b010 : s == SET_SEC ? 3'b001 : 3'b000;
    endfunction

    assign raw      = {btn_down, btn_up, btn_mode};
    assign set_mode = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // rise marks the cycle right after the debounced state flips high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb  <= '0;
            rise <= '0;
            for (int i = 0; i < 3; i++) dcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                rise[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DB_MAX) begin
                    dcnt[i] <= '0;
                    deb[i]  <= sync2[i];
                    rise[i] <= sync2[i];
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RUN;
            en              <= 1'b1;
            signal_increase <= '0;
            signal_decrease <= '0;
            blink_mask      <= '0;
            arm_up          <= 1'b0;
            arm_dn          <= 1'b0;
            first           <= 1'b0;
            rcnt            <= '0;
            bcnt            <= '0;
            phase           <= 1'b0;
        end else begin
            state           <= state_n;
            en              <= en_n;
            signal_increase <= inc_n;
            signal_decrease <= dec_n;
            blink_mask      <= blink_n;
            arm_up          <= arm_up_n;
            arm_dn          <= arm_dn_n;
            first           <= first_n;
            rcnt            <= rcnt_n;
            bcnt            <= bcnt_n;
            phase           <= phase_n;
        end
    end

    // arm_up/arm_dn: repeat is live only for the button whose fresh press produced a pulse
    always_comb begin
        field    = field_of(state);
        both     = deb[1] & deb[2];
        held     = (arm_up & deb[1]) | (arm_dn & deb[2]);
        fire     = rcnt == (first ? DELAY_MAX : RATE_MAX);
        state_n  = state;
        arm_up_n = 1'b0;
        arm_dn_n = 1'b0;
        first_n  = first;
        rcnt_n   = '0;
        inc_n    = '0;
        dec_n    = '0;
        if (rise[0]) begin
            state_n = state_t'(state + 2'd1);
        end else if (state != RUN && !both) begin
            if (rise[1]) begin
                inc_n    = field;
                arm_up_n = 1'b1;
                first_n  = 1'b1;
            end else if (rise[2]) begin
                dec_n    = field;
                arm_dn_n = 1'b1;
                first_n  = 1'b1;
            end else if (held) begin
                arm_up_n = arm_up;
                arm_dn_n = arm_dn;
                first_n  = fire ? 1'b0 : first;
                rcnt_n   = fire ? '0 : rcnt + 1'b1;
                inc_n    = fire && arm_up ? field : 3'b000;
                dec_n    = fire && arm_dn ? field : 3'b000;
            end
        end
        bcnt_n  = '0;
        phase_n = 1'b0;
        if (state_n == state && state != RUN) begin
            bcnt_n  = bcnt == BLINK_MAX ? '0 : bcnt + 1'b1;
            phase_n = bcnt == BLINK_MAX ? ~phase : phase;
        end
        blink_n = phase_n ? field_of(state_n) : 3'b000;
        en_n    = state_n == RUN;
    end
endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: self-checking bench for time_setter with vector table, corner sequences and a timing-level reference model.
module tb_time_setter;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 5;
    localparam int B  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       en;
    logic [2:0] signal_increase, signal_decrease, blink_mask;
    logic [1:0] set_mode;
    int         checks = 0;
    int         errors = 0;

    time_setter #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR),
        .BLINK_HALF(B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_mode(btn_mode),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .en(en),
        .signal_increase(signal_increase),
        .signal_decrease(signal_decrease),
        .set_mode(set_mode),
        .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m, u, d;
        int         hold;
        logic [1:0] mode;
        int         inc, dec;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [2:0] fld(input logic [1:0] m);
        return m == 2'd0 ? 3'b000 : 3'(4 >> (m - 1));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        {btn_mode, btn_up, btn_down} = 3'b000;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_btn(input logic m, input logic u, input logic d, input int hold);
        {btn_mode, btn_up, btn_down} = {m, u, d};
        repeat (hold) tick();
        {btn_mode, btn_up, btn_down} = 3'b000;
        repeat (15) tick();
    endtask

    initial begin
        int         ic, dc, st, pulses, d_t, tp, ts;
        logic [2:0] f, lv, md, mr, nr, inc_e, dec_e;
        logic [D:0] rh [3];
        logic [1:0] ms, dir;
        int         rem [3];

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 10, 2'd1, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 10, 2'd2, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 40, 2'd2, 5, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 10, 2'd3, 0, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 3,  2'd3, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 10, 2'd3, 0, 1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 10, 2'd0, 0, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 10, 2'd0, 0, 0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 10, 2'd1, 0, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 30, 2'd1, 0, 0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 25, 2'd1, 2, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 4,  2'd1, 0, 1};

        do_reset();
        chk("reset set_mode", set_mode, 0);
        chk("reset en", en, 1);
        chk("reset inc", signal_increase, 0);
        chk("reset dec", signal_decrease, 0);
        chk("reset blink", blink_mask, 0);

        // mode press latency and blink phase in SET_HOUR
        btn_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (n == 10) btn_mode = 1'b0;
            tick();
            chk($sformatf("lat set_mode n%0d", n), set_mode, n >= 6 ? 1 : 0);
            chk($sformatf("lat en n%0d", n), en, n < 6 ? 1 : 0);
            chk($sformatf("lat pulses n%0d", n), {signal_increase, signal_decrease}, 0);
            chk($sformatf("lat blink n%0d", n), blink_mask, (n >= 6 && ((n - 6) / B) % 2 == 1) ? 4 : 0);
        end

        do_reset();
        for (int r = 0; r < 12; r++) begin
            ic = 0;
            dc = 0;
            st = 0;
            f  = fld(tbl[r].mode);
            {btn_mode, btn_up, btn_down} = {tbl[r].m, tbl[r].u, tbl[r].d};
            for (int c = 0; c < tbl[r].hold + 15; c++) begin
                if (c == tbl[r].hold) {btn_mode, btn_up, btn_down} = 3'b000;
                tick();
                if (signal_increase != 0 && signal_increase == f && signal_decrease == 0) ic++;
                else if (signal_decrease != 0 && signal_decrease == f && signal_increase == 0) dc++;
                else if ({signal_increase, signal_decrease} != 0) st++;
            end
            chk($sformatf("vec%0d set_mode", r), set_mode, tbl[r].mode);
            chk($sformatf("vec%0d en", r), en, tbl[r].mode == 2'd0 ? 1 : 0);
            chk($sformatf("vec%0d inc count", r), ic, tbl[r].inc);
            chk($sformatf("vec%0d dec count", r), dc, tbl[r].dec);
            chk($sformatf("vec%0d stray pulses", r), st, 0);
        end

        // reset asserted while an auto-repeat pulse is on the output
        do_reset();
        run_btn(1'b1, 1'b0, 1'b0, 10);
        run_btn(1'b1, 1'b0, 1'b0, 10);
        chk("rst-seq set_mode before", set_mode, 2);
        btn_up = 1'b1;
        for (int n = 0; n <= 26; n++) tick();
        chk("rst-seq repeat pulse", signal_increase, 2);
        #2 rst = 1'b1;
        #1;
        chk("rst-seq inc", signal_increase, 0);
        chk("rst-seq dec", signal_decrease, 0);
        chk("rst-seq set_mode", set_mode, 0);
        chk("rst-seq en", en, 1);
        chk("rst-seq blink", blink_mask, 0);
        tick();
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if ({signal_increase, signal_decrease} != 0) pulses++;
        end
        chk("rst-seq held pulses", pulses, 0);
        chk("rst-seq set_mode after", set_mode, 0);
        btn_up = 1'b0;

        // randomized run against a timing-level reference model
        do_reset();
        md = '0;
        mr = '0;
        for (int i = 0; i < 3; i++) begin
            rh[i]  = '0;
            rem[i] = 0;
        end
        lv  = '0;
        ms  = 2'd0;
        dir = 2'd0;
        tp  = 0;
        ts  = 0;
        for (int n = 0; n < 5000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (rem[i] == 0) begin
                    lv[i]  = ~lv[i];
                    rem[i] = i == 0 ? (lv[i] ? int'($urandom_range(1, 10)) : int'($urandom_range(40, 250)))
                                    : (lv[i] ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 60)));
                end
                rem[i]--;
            end
            {btn_down, btn_up, btn_mode} = lv;
            tick();
            inc_e = '0;
            dec_e = '0;
            f = fld(ms);
            if (mr[0]) begin
                ms  = ms + 2'd1;
                ts  = n;
                dir = 2'd0;
            end else if (ms == 2'd0 || (md[1] && md[2])) begin
                dir = 2'd0;
            end else if (mr[1]) begin
                inc_e = f;
                dir   = 2'd1;
                tp    = n;
            end else if (mr[2]) begin
                dec_e = f;
                dir   = 2'd2;
                tp    = n;
            end else if ((dir == 2'd1 && md[1]) || (dir == 2'd2 && md[2])) begin
                d_t = n - tp;
                if (d_t == RD || (d_t > RD && (d_t - RD) % RR == 0)) begin
                    if (dir == 2'd1) inc_e = f;
                    else dec_e = f;
                end
            end else begin
                dir = 2'd0;
            end
            for (int i = 0; i < 3; i++) begin
                nr[i] = 1'b0;
                if (rh[i][D:1] == {D{~md[i]}}) begin
                    md[i] = ~md[i];
                    nr[i] = md[i];
                end
                rh[i] = {rh[i][D-1:0], lv[i]};
            end
            mr = nr;
            chk($sformatf("rand inc n%0d", n), signal_increase, inc_e);
            chk($sformatf("rand dec n%0d", n), signal_decrease, dec_e);
            chk($sformatf("rand set_mode n%0d", n), set_mode, ms);
            chk($sformatf("rand en n%0d", n), en, ms == 2'd0 ? 1 : 0);
            chk($sformatf("rand blink n%0d", n), blink_mask,
                (ms != 2'd0 && ((n - ts) / B) % 2 == 1) ? int'(fld(ms)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
